// File: rtl/keypad_pkg.sv
// Shared codes, FSM state type and column-decode helpers for the kiosk keypad scanner.
package keypad_pkg;

  localparam logic [4:0] KEY_START = 5'd10;
  localparam logic [4:0] KEY_CLEAR = 5'd11;
  localparam logic [4:0] KEY_ENTER = 5'd12;
  localparam logic [4:0] NUM_IDLE  = 5'd31;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, ARM, HELD} state_e;

  // True when exactly one line of an active-low nibble is pulled low.
  function automatic logic single_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_key_encode.sv
// Maps a latched row/column position of the 4x4 keypad to its key code and function flags.
module keypad_key_encode
  import keypad_pkg::*;
(
  input  logic [1:0] row_i,
  input  logic [1:0] col_i,
  output logic [4:0] code_o,
  output logic       start_o,
  output logic       clear_o,
  output logic       enter_o
);

  always_comb begin
    code_o = NUM_IDLE;
    unique case ({row_i, col_i})
      4'h0: code_o = 5'd1;
      4'h1: code_o = 5'd2;
      4'h2: code_o = 5'd3;
      4'h3: code_o = KEY_START;
      4'h4: code_o = 5'd4;
      4'h5: code_o = 5'd5;
      4'h6: code_o = 5'd6;
      4'h7: code_o = KEY_CLEAR;
      4'h8: code_o = 5'd7;
      4'h9: code_o = 5'd8;
      4'hA: code_o = 5'd9;
      4'hB: code_o = KEY_ENTER;
      4'hC: code_o = 5'd13;
      4'hD: code_o = 5'd0;
      4'hE: code_o = 5'd14;
      4'hF: code_o = 5'd15;
      default: code_o = NUM_IDLE;
    endcase
    start_o = (code_o == KEY_START);
    clear_o = (code_o == KEY_CLEAR);
    enter_o = (code_o == KEY_ENTER);
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with press/release debounce and level-style key outputs.
// Define KEYPAD_REPEAT_EN to auto-repeat startSet while a digit key stays held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 25,
  parameter int unsigned DEB_CYC    = 250,
  parameter int unsigned REPEAT_CYC = 12500
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [4:0] num,
  output logic       start,
  output logic       clear,
  output logic       enter,
  output logic       startSet
);

  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYC - 1);

  state_e           state_q;
  logic [3:0]       row_q;
  logic [ScanW-1:0] scan_cnt_q;
  logic [DebW-1:0]  deb_cnt_q;
  logic [1:0]       key_row_q;
  logic [1:0]       key_col_q;
  logic [3:0]       key_pat_q;
  logic [4:0]       num_q;
  logic             start_q;
  logic             clear_q;
  logic             enter_q;
  logic             valid_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  // Drop one cycle before the period ends so rising edges are REPEAT_CYC apart.
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYC - 2);
  logic [RepW-1:0] rep_cnt_q;
`endif

  logic [4:0] enc_code;
  logic       enc_start;
  logic       enc_clear;
  logic       enc_enter;

  keypad_key_encode u_encode (
    .row_i   (key_row_q),
    .col_i   (key_col_q),
    .code_o  (enc_code),
    .start_o (enc_start),
    .clear_o (enc_clear),
    .enter_o (enc_enter)
  );

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= SCAN;
      row_q      <= 4'b1110;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      key_row_q  <= 2'd0;
      key_col_q  <= 2'd0;
      key_pat_q  <= 4'hF;
      num_q      <= NUM_IDLE;
      start_q    <= 1'b0;
      clear_q    <= 1'b0;
      enter_q    <= 1'b0;
      valid_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        SCAN: begin
          if (scan_cnt_q == ScanLast) begin
            scan_cnt_q <= '0;
            if (single_low(col_in)) begin
              key_row_q <= low_idx(row_q);
              key_col_q <= low_idx(col_in);
              key_pat_q <= col_in;
              deb_cnt_q <= '0;
              state_q   <= DEB_PRESS;
            end else begin
              // Idle columns and multi-key ghosts both just advance the scan.
              row_q <= {row_q[2:0], row_q[3]};
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (col_in != key_pat_q) begin
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else if (deb_cnt_q == DebLast) begin
            num_q     <= enc_code;
            start_q   <= enc_start;
            clear_q   <= enc_clear;
            enter_q   <= enc_enter;
            deb_cnt_q <= '0;
            state_q   <= ARM;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        ARM: begin
          valid_q   <= 1'b1;
          deb_cnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_q <= '0;
`endif
          state_q   <= HELD;
        end
        HELD: begin
`ifdef KEYPAD_REPEAT_EN
          if (num_q < KEY_START) begin
            if (!valid_q) begin
              valid_q   <= 1'b1;
              rep_cnt_q <= '0;
            end else if (rep_cnt_q == RepLast) begin
              valid_q   <= 1'b0;
              rep_cnt_q <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + 1'b1;
            end
          end
`endif
          if (col_in != 4'hF) begin
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DebLast) begin
            valid_q    <= 1'b0;
            num_q      <= NUM_IDLE;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            enter_q    <= 1'b0;
            deb_cnt_q  <= '0;
            row_q      <= 4'b1110;
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign row_out  = row_q;
  assign num      = num_q;
  assign start    = start_q;
  assign clear    = clear_q;
  assign enter    = enter_q;
  assign startSet = valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a matrix model drives col_in, a scoreboard checks each startSet.
module tb_keypad_scan;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic [4:0] num;
  logic       start_o;
  logic       clear_o;
  logic       enter_o;
  logic       ss;
  logic [15:0] keys = '0;

  typedef struct packed {
    logic [4:0] num;
    logic       s;
    logic       c;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rises = 0;
  int   base;
  int   n_exp;
  logic [3:0] exp_row;
  logic [3:0] one = 4'b0001;

  always #5 clk = ~clk;

  keypad_scan dut (
    .CLK      (clk),
    .RSTn     (rstn),
    .col_in   (col),
    .row_out  (row),
    .num      (num),
    .start    (start_o),
    .clear    (clear_o),
    .enter    (enter_o),
    .startSet (ss)
  );

  // Pressed key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] n, input logic s, input logic c, input logic e);
    exp_t x;
    x.num = n;
    x.s   = s;
    x.c   = c;
    x.e   = e;
    return x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ss(input string tag, input int budget);
    int k;
    k = 0;
    while (ss !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, ss, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (num !== 5'd31 && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, num, 31);
  endtask

  // Scoreboard: every startSet rising edge consumes one expected key.
  logic       ss_prev  = 1'b0;
  logic [4:0] num_prev = 5'd31;
  always @(negedge clk) begin
    if (ss === 1'b1 && ss_prev !== 1'b1) begin
      rises++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_unexpected_startSet: observed num %0d with empty queue", num);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_num", num, e.num);
        check("sb_start", start_o, e.s);
        check("sb_clear", clear_o, e.c);
        check("sb_enter", enter_o, e.e);
        check("sb_num_before_startSet", num_prev, e.num);
      end
    end
    ss_prev  <= ss;
    num_prev <= num;
  end

  initial begin
    // Reset values.
    tick(3);
    check("rst_row", row, 4'b1110);
    check("rst_num", num, 31);
    check("rst_startSet", ss, 0);
    check("rst_flags", {start_o, clear_o, enter_o}, 0);
    rstn = 1'b1;

    // Idle scan: row k/25 is driven after k edges.
    for (int k = 1; k <= 200; k++) begin
      tick(1);
      if (k % 25 == 0 || k % 25 == 24) begin
        exp_row = ~(one << ((k / 25) % 4));
        check("scan_row", row, exp_row);
      end
    end
    check("idle_num", num, 31);
    check("idle_startSet", ss, 0);

    // Key 5: row1 sampled 50 edges in, then 250 debounce edges.
    keys[5] = 1'b1;
    exp_q.push_back(mk(5'd5, 0, 0, 0));
    tick(299);
    check("k5_before_accept", num, 31);
    tick(1);
    check("k5_accept_num", num, 5);
    check("k5_startSet_lags", ss, 0);
    tick(1);
    check("k5_startSet_rise", ss, 1);
    tick(99);
    check("k5_held_num", num, 5);
    check("k5_held_startSet", ss, 1);
    keys = '0;
    tick(249);
    check("k5_release_early", num, 5);
    tick(1);
    check("k5_release_num", num, 31);
    check("k5_release_startSet", ss, 0);
    check("k5_release_row", row, 4'b1110);

    // Bouncing enter (r2c3).
    base = rises;
    exp_q.push_back(mk(5'd12, 0, 0, 1));
    for (int i = 0; i < 20; i++) begin
      keys[11] = (i % 2 == 0);
      tick(3);
    end
    keys[11] = 1'b1;
    wait_ss("enter_accept", 1000);
    tick(50);
    check("enter_flag", enter_o, 1);
    check("enter_num", num, 12);
    keys = '0;
    wait_idle("enter_release", 600);
    check("enter_one_edge", rises - base, 1);

    // Ghost pair r0c0 + r0c1: scan starts at row0 right after release.
    base = rises;
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    tick(25);
    check("ghost_rotates", row, 4'b1101);
    tick(575);
    check("ghost_no_startSet", rises - base, 0);
    check("ghost_num", num, 31);
    keys = '0;
    tick(100);

    // Hold 7 (r2c0) for 30000 cycles.
    base = rises;
`ifdef KEYPAD_REPEAT_EN
    n_exp = 3;
`else
    n_exp = 1;
`endif
    for (int i = 0; i < n_exp; i++) exp_q.push_back(mk(5'd7, 0, 0, 0));
    keys[8] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1000);
      if (i >= 1) check("hold7_num", num, 7);
    end
    check("hold7_edges", rises - base, n_exp);
    keys = '0;
    wait_idle("hold7_release", 600);

    // Reset while start key is held.
    exp_q.push_back(mk(5'd10, 1, 0, 0));
    keys[3] = 1'b1;
    wait_ss("start_accept", 1000);
    check("start_flag", start_o, 1);
    rstn = 1'b0;
    tick(1);
    check("midrst_row", row, 4'b1110);
    check("midrst_num", num, 31);
    check("midrst_startSet", ss, 0);
    check("midrst_flags", {start_o, clear_o, enter_o}, 0);
    keys = '0;
    tick(2);
    rstn = 1'b1;
    tick(10);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
